// File: rtl/ir_scan_ctrl.sv
// ir_scan_ctrl: round-robin RC-decay IR sensor scanner with a valid/ready result port.
// Define IR_CAL_EN to add baseline capture (cal_req) and per-channel hit flags.
module ir_scan_ctrl #(
    parameter int NUM_CH     = 4,
    parameter int CHARGE_CYC = 64,
    parameter int CNT_W      = 16,
    parameter int TIMEOUT    = 50000,
    parameter int CAL_TOL    = 6
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      run,
    input  logic [NUM_CH-1:0]         sig_in,
    output logic [NUM_CH-1:0]         sig_oe,
    output logic [NUM_CH-1:0]         sig_drive,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [$clog2(NUM_CH)-1:0] res_ch,
    output logic [CNT_W-1:0]          res_data,
    output logic                      res_timeout,
`ifdef IR_CAL_EN
    input  logic                      cal_req,
    output logic [NUM_CH-1:0]         hit,
`endif
    output logic                      busy
);

    localparam int CH_W = $clog2(NUM_CH);
    localparam int TM_W = (CHARGE_CYC > 1) ? $clog2(CHARGE_CYC) : 1;

    localparam logic [TM_W-1:0]   TM_LAST = TM_W'(CHARGE_CYC - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT);
    localparam logic [CH_W-1:0]   CH_LAST = CH_W'(NUM_CH - 1);
    localparam logic [NUM_CH-1:0] ONE     = NUM_CH'(1);

    if (NUM_CH < 2 || NUM_CH > 8 || CHARGE_CYC < 1 ||
        TIMEOUT >= 2**CNT_W || CAL_TOL < 0) begin : g_bad_params
        $error("ir_scan_ctrl: illegal parameter set");
    end

    typedef enum logic [1:0] {
        IDLE,
        CHARGE,
        MEASURE,
        REPORT
    } state_t;

    state_t            state;
    logic [CH_W-1:0]   ch;
    logic [CH_W-1:0]   ch_nxt;
    logic [TM_W-1:0]   tmr;
    logic [CNT_W-1:0]  cnt;
    logic [NUM_CH-1:0] sync1;
    logic [NUM_CH-1:0] sync2;
    logic              last_ch;
    logic              hs;
    logic              go_on;

    // Pins are asynchronous to clk; the 2-cycle lag is part of every count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= sig_in;
            sync2 <= sync1;
        end
    end

    assign last_ch = (ch == CH_LAST);
    assign ch_nxt  = last_ch ? '0 : ch + 1'b1;
    assign hs      = (state == REPORT) && res_ready;
    assign go_on   = !last_ch || run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ch          <= '0;
            tmr         <= '0;
            cnt         <= '0;
            sig_oe      <= '0;
            sig_drive   <= '0;
            res_valid   <= 1'b0;
            res_ch      <= '0;
            res_data    <= '0;
            res_timeout <= 1'b0;
            busy        <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (run) begin
                        state     <= CHARGE;
                        ch        <= '0;
                        tmr       <= '0;
                        sig_oe    <= ONE;
                        sig_drive <= ONE;
                        busy      <= 1'b1;
                    end
                end
                CHARGE: begin
                    if (tmr == TM_LAST) begin
                        state     <= MEASURE;
                        sig_oe    <= '0;
                        sig_drive <= '0;
                        cnt       <= '0;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                MEASURE: begin
                    if (!sync2[ch]) begin
                        state       <= REPORT;
                        res_valid   <= 1'b1;
                        res_ch      <= ch;
                        res_data    <= cnt;
                        res_timeout <= 1'b0;
                    end else if (cnt == CNT_MAX) begin
                        state       <= REPORT;
                        res_valid   <= 1'b1;
                        res_ch      <= ch;
                        res_data    <= CNT_MAX;
                        res_timeout <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                REPORT: begin
                    // run only matters once the last channel has been taken
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if (go_on) begin
                            state     <= CHARGE;
                            ch        <= ch_nxt;
                            tmr       <= '0;
                            sig_oe    <= ONE << ch_nxt;
                            sig_drive <= ONE << ch_nxt;
                        end else begin
                            state <= IDLE;
                            ch    <= '0;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef IR_CAL_EN
    localparam logic [CNT_W:0] TOL = (CNT_W + 1)'(CAL_TOL);

    logic             cal_arm;
    logic             ch0_entry;
    logic [CNT_W-1:0] base [NUM_CH];
    logic [CNT_W:0]   cur_w;
    logic [CNT_W:0]   base_w;
    logic [CNT_W:0]   diff;

    assign ch0_entry = ((state == IDLE) && run) || (hs && last_ch && run);
    assign cur_w     = {1'b0, res_data};
    assign base_w    = {1'b0, base[res_ch]};
    assign diff      = (cur_w >= base_w) ? cur_w - base_w : base_w - cur_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cal_arm <= 1'b0;
            hit     <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                base[i] <= '0;
            end
        end else begin
            if (ch0_entry) begin
                cal_arm <= cal_req;
            end
            if (hs) begin
                if (cal_arm) begin
                    base[res_ch] <= res_data;
                    hit[res_ch]  <= 1'b0;
                end else begin
                    hit[res_ch] <= (diff <= TOL) && !res_timeout;
                end
            end
        end
    end
`endif

endmodule
